// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter for N requesters sharing one
// downstream port.
//
// A winner is chosen from the request vector in rotating-priority order
// starting at ptr. The grant is registered and held for up to weight[i]
// accepted beats (weight 0 behaves as 1). It is released early on a beat with
// last, or when the granted requester drops its request. At least one IDLE
// cycle always separates two grants.
//
// Ports:
//   clk          clock
//   rst_n        synchronous, active-low reset
//   req[N]       level requests, held until serviced
//   weight       burst quantum per requester, field i = weight[i*WBITS +: WBITS]
//   beat         consumer accepted one transfer from the granted requester
//   last         accepted beat ends the packet (qualified by beat)
//   grant[N]     registered one-hot grant
//   grant_idx    binary index of the granted requester (holds when idle)
//   grant_valid  registered OR of grant
module wrr_arbiter #(
  parameter int N     = 4,
  parameter int WBITS = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WBITS-1:0] weight,
  input  logic               beat,
  input  logic               last,
  output logic [N-1:0]       grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WBITS-1:0] cnt_q, cnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IW-1:0]    grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [WBITS-1:0] win_weight;
  logic             release_c;
  int               cand;

  // Rotating-priority search: the first active request at ptr, ptr+1, ...
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Weight is sampled only at grant time; a zero weight still buys one beat.
  always_comb begin
    win_weight = weight[int'(win_idx)*WBITS +: WBITS];
    if (win_weight == '0) win_weight = WBITS'(1);
  end

  // A dropped request releases even without a beat. A beat landing on the
  // same cycle as the drop is still counted by the consumer.
  assign release_c = (beat && (cnt_q == WBITS'(1))) ||
                     (beat && last) ||
                     !req[grant_idx_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        // beat/last are ignored here.
        if (win_found) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_idx_d      = win_idx;
          grant_valid_d    = 1'b1;
          cnt_d            = win_weight;
          ptr_d            = (int'(win_idx) == N - 1) ? '0 : IW'(int'(win_idx) + 1);
        end
      end
      GRANT: begin
        // Guard against underflow; release is forced at cnt == 1 anyway.
        if (beat && (cnt_q != '0)) cnt_d = cnt_q - WBITS'(1);
        if (release_c) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed testbench for wrr_arbiter (N = 4, WBITS = 4).
module tb_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [15:0] weight = 16'h4321;
  logic        beat = 1'b0;
  logic        last = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_valid;

  int n_checks = 0;
  int n_errors = 0;

  wrr_arbiter #(.N(4), .WBITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .beat        (beat),
    .last        (last),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs applied for one cycle and the outputs expected after that edge.
  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        beat;
    logic        last;
    logic [15:0] weight;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_idx;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  int beats[4];
  int grants;
  int run_len;
  int cur_idx;
  logic prev_valid;
  logic done;

  initial begin
    // reset with all requests pending
    vecs[0]  = '{1'b0, 4'hF, 1'b0, 1'b0, 16'h4321, 4'h0, 2'd0};
    vecs[1]  = '{1'b0, 4'hF, 1'b0, 1'b0, 16'h4321, 4'h0, 2'd0};
    // first IDLE cycle -> grant to 0
    vecs[2]  = '{1'b1, 4'hF, 1'b0, 1'b0, 16'h4321, 4'h1, 2'd0};
    vecs[3]  = '{1'b1, 4'hF, 1'b1, 1'b0, 16'h4321, 4'h0, 2'd0};
    // requester 1 with weight 0: exactly one beat
    vecs[4]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0500, 4'h2, 2'd1};
    vecs[5]  = '{1'b1, 4'h6, 1'b0, 1'b0, 16'h0500, 4'h2, 2'd1};
    vecs[6]  = '{1'b1, 4'h6, 1'b1, 1'b0, 16'h0500, 4'h0, 2'd1};
    // requester 2 with weight 5: last on 2nd beat
    vecs[7]  = '{1'b1, 4'h4, 1'b0, 1'b0, 16'h0500, 4'h4, 2'd2};
    vecs[8]  = '{1'b1, 4'h4, 1'b1, 1'b0, 16'h0500, 4'h4, 2'd2};
    vecs[9]  = '{1'b1, 4'h4, 1'b1, 1'b1, 16'h0500, 4'h0, 2'd2};
    // requester 3 drops its request without a beat
    vecs[10] = '{1'b1, 4'h8, 1'b0, 1'b0, 16'h4321, 4'h8, 2'd3};
    vecs[11] = '{1'b1, 4'h8, 1'b0, 1'b0, 16'h4321, 4'h8, 2'd3};
    vecs[12] = '{1'b1, 4'h0, 1'b0, 1'b0, 16'h4321, 4'h0, 2'd3};
    vecs[13] = '{1'b1, 4'h3, 1'b0, 1'b0, 16'h4321, 4'h1, 2'd0};
    vecs[14] = '{1'b1, 4'h3, 1'b1, 1'b0, 16'h4321, 4'h0, 2'd0};
    // only 3 requests; then 1001 goes to 0 after the pointer wraps
    vecs[15] = '{1'b1, 4'h8, 1'b0, 1'b0, 16'h4321, 4'h8, 2'd3};
    vecs[16] = '{1'b1, 4'h8, 1'b1, 1'b1, 16'h4321, 4'h0, 2'd3};
    vecs[17] = '{1'b1, 4'h9, 1'b0, 1'b0, 16'h4321, 4'h1, 2'd0};
    vecs[18] = '{1'b1, 4'h9, 1'b1, 1'b0, 16'h4321, 4'h0, 2'd0};
    // weight of 3 raised to 15 mid-burst: still 4 beats
    vecs[19] = '{1'b1, 4'h9, 1'b0, 1'b0, 16'h4321, 4'h8, 2'd3};
    vecs[20] = '{1'b1, 4'h9, 1'b1, 1'b0, 16'hF321, 4'h8, 2'd3};
    vecs[21] = '{1'b1, 4'h9, 1'b1, 1'b0, 16'hF321, 4'h8, 2'd3};
    vecs[22] = '{1'b1, 4'h9, 1'b1, 1'b0, 16'hF321, 4'h8, 2'd3};
    vecs[23] = '{1'b1, 4'h9, 1'b1, 1'b0, 16'hF321, 4'h0, 2'd3};
    // reset during a grant, then restart from index 0
    vecs[24] = '{1'b1, 4'h4, 1'b0, 1'b0, 16'h4321, 4'h4, 2'd2};
    vecs[25] = '{1'b0, 4'hF, 1'b0, 1'b0, 16'h4321, 4'h0, 2'd0};
    vecs[26] = '{1'b1, 4'hF, 1'b0, 1'b0, 16'h4321, 4'h1, 2'd0};
    vecs[27] = '{1'b1, 4'hF, 1'b1, 1'b0, 16'h4321, 4'h0, 2'd0};
    // beat+last in IDLE must not shorten the next burst (weight 2)
    vecs[28] = '{1'b1, 4'hF, 1'b1, 1'b1, 16'h4321, 4'h2, 2'd1};
    vecs[29] = '{1'b1, 4'hF, 1'b1, 1'b0, 16'h4321, 4'h2, 2'd1};
    vecs[30] = '{1'b1, 4'hF, 1'b1, 1'b0, 16'h4321, 4'h0, 2'd1};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n  = vecs[i].rst_n;
      req    = vecs[i].req;
      beat   = vecs[i].beat;
      last   = vecs[i].last;
      weight = vecs[i].weight;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d grant_idx", i), 32'(grant_idx), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].exp_grant != 4'h0));
    end

    // Weighted share under continuous load: weights 1/2/3/4, beat every cycle.
    @(negedge clk);
    rst_n  = 1'b0;
    req    = 4'hF;
    beat   = 1'b1;
    last   = 1'b0;
    weight = 16'h4321;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) beats[k] = 0;
    grants     = 0;
    run_len    = 0;
    cur_idx    = 0;
    prev_valid = 1'b0;
    done       = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      if (grant_valid) begin
        if (!prev_valid) begin
          check($sformatf("share grant%0d idx", grants), 32'(grant_idx), 32'(grants % 4));
          grants++;
          run_len = 0;
          cur_idx = int'(grant_idx);
        end
        run_len++;
        beats[grant_idx]++;
      end else if (prev_valid) begin
        check($sformatf("share grant%0d length", grants - 1), 32'(run_len), 32'(cur_idx + 1));
        if (grants == 100) done = 1'b1;
      end
      prev_valid = grant_valid;
    end
    check("share completed 100 grants", 32'(done), 32'd1);
    check("share beats idx0", 32'(beats[0]), 32'd25);
    check("share beats idx1", 32'(beats[1]), 32'd50);
    check("share beats idx2", 32'(beats[2]), 32'd75);
    check("share beats idx3", 32'(beats[3]), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
